// File: rtl/cntr_pkg.sv
// Shared defaults and step-mode encoding for the up/down modulo counter.
package cntr_pkg;

  localparam int unsigned N_DEF  = 16;
  localparam int unsigned PW_DEF = 8;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_e;

endpackage

// File: rtl/presc_nb.sv
// Prescaler: PW-bit counter that strobes tick when it reaches pre, then restarts.
module presc_nb #(
  parameter int unsigned PW = cntr_pkg::PW_DEF
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          sclr,
  input  logic          en,
  input  logic [PW-1:0] pre,
  output logic          tick
);

  logic [PW-1:0] p_q;
  logic [PW-1:0] p_d;

  // Step strobe: one en cycle in every pre+1.
  assign tick = en && (p_q == pre);

  // Next prescaler value: clear wins, otherwise advance only while enabled.
  always_comb begin
    p_d = p_q;
    if (sclr) begin
      p_d = '0;
    end else if (en) begin
      p_d = tick ? '0 : p_q + PW'(1);
    end
  end

  // Prescaler state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

endmodule

// File: rtl/cntr_updn_mod_nb.sv
// Up/down counter over 0..max with wrap or saturate, prescaled stepping and load.
module cntr_updn_mod_nb
  import cntr_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned PW = PW_DEF
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          sclr,
  input  logic          en,
  input  logic          up,
  input  logic          dn,
  input  logic          ld,
  input  logic [N-1:0]  D,
  input  logic [N-1:0]  max,
  input  logic          sat,
  input  logic [PW-1:0] pre,
  output logic [N-1:0]  count,
  output logic          tc,
  output logic          rco,
  output logic          tick
);

  logic [N-1:0] count_q;
  logic [N-1:0] count_d;
  logic         rco_q;
  logic         rco_d;
  logic         presc_clr_c;
  step_e        step_c;

  // A load also restarts the prescaler so the next step is a full period away.
  assign presc_clr_c = sclr || ld;

  presc_nb #(
    .PW (PW)
  ) u_presc (
    .clk  (clk),
    .clr  (clr),
    .sclr (presc_clr_c),
    .en   (en),
    .pre  (pre),
    .tick (tick)
  );

  // Decode the step request; conflicting or absent direction holds.
  always_comb begin
    step_c = STEP_HOLD;
    if (tick && up && !dn) begin
      step_c = STEP_UP;
    end else if (tick && dn && !up) begin
      step_c = STEP_DOWN;
    end
  end

  // Next count and wrap pulse: sclr, then ld, then step, then hold.
  always_comb begin
    count_d = count_q;
    rco_d   = 1'b0;
    if (sclr) begin
      count_d = '0;
    end else if (ld) begin
      count_d = D;
    end else begin
      case (step_c)
        STEP_UP: begin
          if (count_q >= max) begin
            if (sat) begin
              count_d = max;
            end else begin
              count_d = '0;
              rco_d   = 1'b1;
            end
          end else begin
            count_d = count_q + N'(1);
          end
        end
        STEP_DOWN: begin
          if (count_q == '0) begin
            if (!sat) begin
              count_d = max;
              rco_d   = 1'b1;
            end
          end else if (count_q > max) begin
            count_d = max;
          end else begin
            count_d = count_q - N'(1);
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Count and wrap-pulse registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
      rco_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      rco_q   <= rco_d;
    end
  end

  // Terminal count looks at the requested direction, not at tick.
  assign tc    = (up && !dn && (count_q >= max)) || (dn && !up && (count_q == '0));
  assign count = count_q;
  assign rco   = rco_q;

endmodule

// File: tb/tb_cntr_updn_mod_nb.sv
// Directed bench for cntr_updn_mod_nb with N=4, PW=4.
module tb_cntr_updn_mod_nb;

  localparam int unsigned N  = 4;
  localparam int unsigned PW = 4;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          sclr = 1'b0;
  logic          en = 1'b0;
  logic          up = 1'b0;
  logic          dn = 1'b0;
  logic          ld = 1'b0;
  logic [N-1:0]  D = '0;
  logic [N-1:0]  max = 4'd9;
  logic          sat = 1'b0;
  logic [PW-1:0] pre = '0;
  logic [N-1:0]  count;
  logic          tc;
  logic          rco;
  logic          tick;

  int n_total = 0;
  int n_bad   = 0;

  cntr_updn_mod_nb #(
    .N  (N),
    .PW (PW)
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .sclr  (sclr),
    .en    (en),
    .up    (up),
    .dn    (dn),
    .ld    (ld),
    .D     (D),
    .max   (max),
    .sat   (sat),
    .pre   (pre),
    .count (count),
    .tc    (tc),
    .rco   (rco),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #1 clr = 1'b1;
    #2;
    n_total++;
    if (count !== 4'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_total++;
    if (rco !== 1'b0) begin n_bad++; $display("FAIL reset_rco got=%0b exp=0", rco); end
    n_total++;
    if (tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got=%0b exp=0", tick); end
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_up_wrap();
    logic [N-1:0] exp_c;
    max = 4'd9; pre = '0; sat = 1'b0; en = 1'b1; up = 1'b1; dn = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      exp_c = N'(i % 10);
      n_total++;
      if (count !== exp_c) begin n_bad++; $display("FAIL up_wrap_count[%0d] got=%0d exp=%0d", i, count, exp_c); end
      n_total++;
      if (rco !== (i == 10)) begin n_bad++; $display("FAIL up_wrap_rco[%0d] got=%0b exp=%0b", i, rco, (i == 10)); end
      n_total++;
      if (tc !== (exp_c == 4'd9)) begin n_bad++; $display("FAIL up_wrap_tc[%0d] got=%0b exp=%0b", i, tc, (exp_c == 4'd9)); end
      n_total++;
      if (tick !== 1'b1) begin n_bad++; $display("FAIL up_wrap_tick[%0d] got=%0b exp=1", i, tick); end
    end
  endtask

  task automatic test_sat_down();
    logic [N-1:0] exp_seq [4];
    exp_seq[0] = 4'd1; exp_seq[1] = 4'd0; exp_seq[2] = 4'd0; exp_seq[3] = 4'd0;
    up = 1'b0; dn = 1'b0; ld = 1'b1; D = 4'd2; max = 4'd5; sat = 1'b1;
    @(negedge clk);
    ld = 1'b0; dn = 1'b1;
    #1;
    n_total++;
    if (count !== 4'd2) begin n_bad++; $display("FAIL sat_load got=%0d exp=2", count); end
    n_total++;
    if (tc !== 1'b0) begin n_bad++; $display("FAIL sat_tc_at2 got=%0b exp=0", tc); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++;
      if (count !== exp_seq[i]) begin n_bad++; $display("FAIL sat_down_count[%0d] got=%0d exp=%0d", i, count, exp_seq[i]); end
      n_total++;
      if (rco !== 1'b0) begin n_bad++; $display("FAIL sat_down_rco[%0d] got=%0b exp=0", i, rco); end
      n_total++;
      if (tc !== (exp_seq[i] == 4'd0)) begin n_bad++; $display("FAIL sat_down_tc[%0d] got=%0b exp=%0b", i, tc, (exp_seq[i] == 4'd0)); end
    end
  endtask

  task automatic test_prescale();
    logic [N-1:0] exp_c;
    dn = 1'b0; up = 1'b1; sat = 1'b0; max = 4'd9; pre = 4'd3; ld = 1'b1; D = 4'd0; en = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    #1;
    n_total++;
    if (tick !== 1'b0) begin n_bad++; $display("FAIL presc_tick_after_ld got=%0b exp=0", tick); end
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      exp_c = N'(e / 4);
      n_total++;
      if (count !== exp_c) begin n_bad++; $display("FAIL presc_count[%0d] got=%0d exp=%0d", e, count, exp_c); end
      n_total++;
      if (tick !== ((e % 4) == 3)) begin n_bad++; $display("FAIL presc_tick[%0d] got=%0b exp=%0b", e, tick, ((e % 4) == 3)); end
    end
    for (int e = 9; e <= 14; e++) begin
      en = (e > 10);
      @(negedge clk);
      exp_c = (e == 14) ? 4'd3 : 4'd2;
      n_total++;
      if (count !== exp_c) begin n_bad++; $display("FAIL presc_stretch_count[%0d] got=%0d exp=%0d", e, count, exp_c); end
    end
    en = 1'b1;
  endtask

  task automatic test_ld_over_max();
    pre = '0; en = 1'b1; up = 1'b0; dn = 1'b0; sat = 1'b0; max = 4'd9; ld = 1'b1; D = 4'd12;
    @(negedge clk);
    ld = 1'b0; up = 1'b1;
    #1;
    n_total++;
    if (count !== 4'd12) begin n_bad++; $display("FAIL ldmax_load_up got=%0d exp=12", count); end
    n_total++;
    if (tc !== 1'b1) begin n_bad++; $display("FAIL ldmax_tc got=%0b exp=1", tc); end
    @(negedge clk);
    n_total++;
    if (count !== 4'd0) begin n_bad++; $display("FAIL ldmax_up_wrap got=%0d exp=0", count); end
    n_total++;
    if (rco !== 1'b1) begin n_bad++; $display("FAIL ldmax_up_rco got=%0b exp=1", rco); end
    up = 1'b0; ld = 1'b1; D = 4'd12;
    @(negedge clk);
    n_total++;
    if (count !== 4'd12) begin n_bad++; $display("FAIL ldmax_load_dn got=%0d exp=12", count); end
    n_total++;
    if (rco !== 1'b0) begin n_bad++; $display("FAIL ldmax_ld_rco got=%0b exp=0", rco); end
    ld = 1'b0; dn = 1'b1;
    @(negedge clk);
    n_total++;
    if (count !== 4'd9) begin n_bad++; $display("FAIL ldmax_dn_clip got=%0d exp=9", count); end
    n_total++;
    if (rco !== 1'b0) begin n_bad++; $display("FAIL ldmax_dn_rco got=%0b exp=0", rco); end
    dn = 1'b0;
  endtask

  task automatic test_clr_sclr();
    pre = '0; en = 1'b1; up = 1'b1; dn = 1'b0; max = 4'd9; sat = 1'b0; ld = 1'b1; D = 4'd6;
    @(negedge clk);
    ld = 1'b0;
    @(negedge clk);
    n_total++;
    if (count !== 4'd7) begin n_bad++; $display("FAIL clr_pre_count got=%0d exp=7", count); end
    #2 clr = 1'b1;
    #1;
    n_total++;
    if (count !== 4'd0) begin n_bad++; $display("FAIL clr_async got=%0d exp=0", count); end
    #1 clr = 1'b0;
    @(negedge clk);
    n_total++;
    if (count !== 4'd1) begin n_bad++; $display("FAIL clr_resume got=%0d exp=1", count); end
    sclr = 1'b1; ld = 1'b1; D = 4'd5;
    @(negedge clk);
    n_total++;
    if (count !== 4'd0) begin n_bad++; $display("FAIL sclr_over_ld got=%0d exp=0", count); end
    sclr = 1'b0; ld = 1'b0; up = 1'b0;
  endtask

  task automatic test_both_and_max_change();
    pre = '0; en = 1'b1; up = 1'b0; dn = 1'b0; max = 4'd9; sat = 1'b0; ld = 1'b1; D = 4'd5;
    @(negedge clk);
    ld = 1'b0; up = 1'b1; dn = 1'b1;
    #1;
    n_total++;
    if (tc !== 1'b0) begin n_bad++; $display("FAIL both_tc got=%0b exp=0", tc); end
    @(negedge clk);
    n_total++;
    if (count !== 4'd5) begin n_bad++; $display("FAIL both_hold got=%0d exp=5", count); end
    n_total++;
    if (rco !== 1'b0) begin n_bad++; $display("FAIL both_rco got=%0b exp=0", rco); end
    dn = 1'b0; max = 4'd3;
    @(negedge clk);
    n_total++;
    if (count !== 4'd0) begin n_bad++; $display("FAIL maxchg_count got=%0d exp=0", count); end
    n_total++;
    if (rco !== 1'b1) begin n_bad++; $display("FAIL maxchg_rco got=%0b exp=1", rco); end
    @(negedge clk);
    n_total++;
    if (count !== 4'd1) begin n_bad++; $display("FAIL maxchg_next got=%0d exp=1", count); end
    n_total++;
    if (rco !== 1'b0) begin n_bad++; $display("FAIL maxchg_rco_drop got=%0b exp=0", rco); end
  endtask

  task automatic test_max_zero();
    max = 4'd0; sat = 1'b0; up = 1'b1; dn = 1'b0; en = 1'b1; pre = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_total++;
      if (count !== 4'd0) begin n_bad++; $display("FAIL max0_count[%0d] got=%0d exp=0", i, count); end
      n_total++;
      if (rco !== 1'b1) begin n_bad++; $display("FAIL max0_rco[%0d] got=%0b exp=1", i, rco); end
    end
    sat = 1'b1;
    @(negedge clk);
    n_total++;
    if (rco !== 1'b0) begin n_bad++; $display("FAIL max0_sat_rco got=%0b exp=0", rco); end
    up = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_sat_down();
    test_prescale();
    test_ld_over_max();
    test_clr_sclr();
    test_both_and_max_change();
    test_max_zero();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
